// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the 8x1 mux select sequencer.
//   NUM_IN : number of mux data inputs (frame width)
//   SEL_W  : mux select / bit index width
//   GAP_W  : inter-frame gap counter width
//   state_e: sequencer FSM states (idle, serialising, inter-frame gap)
package mux_seq_pkg;

  localparam int unsigned NUM_IN = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned GAP_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/sel_index_counter.sv
// 3-bit loadable up/down bit-index counter with last-index flags.
//   clk, rst_n   : clock, synchronous active-low reset (index -> 0)
//   clr_i        : force index to 0 (highest priority)
//   load_i       : load first index of a frame (0, or 7 when DOWN)
//   step_i       : advance index by one (+1, or -1 when DOWN)
//   idx_o        : registered index
//   last_o       : registered index is the last of a frame
//   last_next_o  : next-cycle index will be the last of a frame
module sel_index_counter
  import mux_seq_pkg::*;
#(
  parameter bit DOWN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             step_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             last_o,
  output logic             last_next_o
);

  localparam logic [SEL_W-1:0] START = DOWN ? '1 : '0;
  localparam logic [SEL_W-1:0] LAST  = DOWN ? '0 : '1;

  logic [SEL_W-1:0] idx_q;
  logic [SEL_W-1:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (load_i) begin
      idx_d = START;
    end else if (step_i) begin
      idx_d = DOWN ? (idx_q - 1'b1) : (idx_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o       = idx_q;
  assign last_o      = (idx_q == LAST);
  assign last_next_o = (idx_d == LAST);

endmodule

// File: rtl/mux_sel_sequencer.sv
// Upstream control for an 8x1 single-bit mux: accepts an 8-bit frame over
// valid/ready, holds it on the mux inputs a..h and steps sel2..sel0 with the
// active-low enable so the mux serialises one bit per clock.
//   clk, rst_n        : clock, synchronous active-low reset
//   data_in[7:0]      : frame (bit0 -> a ... bit7 -> h)
//   data_valid        : data_in valid
//   data_ready        : frame can be accepted this cycle (combinational)
//   abort             : synchronous abort of the frame in RUN/GAP
//   a..h              : registered frame bits to the mux
//   sel0..sel2        : mux select, sel0 = LSB
//   enable            : mux enable, active-low
//   busy              : high in RUN or GAP
//   frame_done        : pulse during the last bit of a frame
// Parameters: MSB_FIRST (0: a first, 1: h first), GAP (idle cycles, 0..15).
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned GAP       = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       abort,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h,
  output logic       sel0,
  output logic       sel1,
  output logic       sel2,
  output logic       enable,
  output logic       busy,
  output logic       frame_done
);

  localparam bit               GAP_EN   = (GAP != 0);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_EN ? GAP_W'(GAP - 1) : '0;

  state_e              state_q, state_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [NUM_IN-1:0]   data_q;
  logic                enable_q, enable_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [SEL_W-1:0]    idx;
  logic                idx_last;
  logic                idx_last_next;
  logic                accept;
  logic                last_run;
  logic                idx_clr;
  logic                idx_step;

  assign last_run = (state_q == ST_RUN) && idx_last;
  assign accept   = data_valid && data_ready;

  // Index returns to 0 on abort and whenever a frame ends without a reload.
  assign idx_clr  = ((state_q != ST_IDLE) && abort) || (last_run && !accept);
  assign idx_step = (state_q == ST_RUN);

  sel_index_counter #(
    .DOWN (MSB_FIRST)
  ) u_idx (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (idx_clr),
    .load_i      (accept),
    .step_i      (idx_step),
    .idx_o       (idx),
    .last_o      (idx_last),
    .last_next_o (idx_last_next)
  );

  always_comb begin
    data_ready = 1'b0;
    case (state_q)
      ST_IDLE: data_ready = 1'b1;
      ST_RUN:  data_ready = !GAP_EN && idx_last && !abort;
      default: data_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (idx_last) begin
          if (GAP_EN) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end else if (accept) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (abort || (gap_q == '0)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with
  // the index register in the same cycle.
  always_comb begin
    enable_d = (state_d != ST_RUN);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_RUN) && idx_last_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gap_q    <= '0;
      data_q   <= '0;
      enable_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      if (accept) data_q <= data_in;
    end
  end

  assign {h, g, f, e, d, c, b, a} = data_q;
  assign {sel2, sel1, sel0}       = idx;
  assign enable                   = enable_q;
  assign busy                     = busy_q;
  // An abort arriving on the last bit cancels that frame's completion pulse.
  assign frame_done               = done_q && !abort;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer: three instances cover LSB-first
// no-gap, MSB-first no-gap and LSB-first GAP=3 configurations.
module tb_mux_sel_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       dv;
  logic       abort;

  logic [7:0] q0, q1, q2;
  logic [2:0] s0, s1, s2;
  logic       en0, en1, en2;
  logic       bz0, bz1, bz2;
  logic       fd0, fd1, fd2;
  logic       rd0, rd1, rd2;

  int n_chk  = 0;
  int n_pass = 0;

  mux_sel_sequencer #(.MSB_FIRST(1'b0), .GAP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(din), .data_valid(dv), .data_ready(rd0),
    .abort(abort), .a(q0[0]), .b(q0[1]), .c(q0[2]), .d(q0[3]), .e(q0[4]),
    .f(q0[5]), .g(q0[6]), .h(q0[7]), .sel0(s0[0]), .sel1(s0[1]), .sel2(s0[2]),
    .enable(en0), .busy(bz0), .frame_done(fd0)
  );

  mux_sel_sequencer #(.MSB_FIRST(1'b1), .GAP(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(din), .data_valid(dv), .data_ready(rd1),
    .abort(abort), .a(q1[0]), .b(q1[1]), .c(q1[2]), .d(q1[3]), .e(q1[4]),
    .f(q1[5]), .g(q1[6]), .h(q1[7]), .sel0(s1[0]), .sel1(s1[1]), .sel2(s1[2]),
    .enable(en1), .busy(bz1), .frame_done(fd1)
  );

  mux_sel_sequencer #(.MSB_FIRST(1'b0), .GAP(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .data_in(din), .data_valid(dv), .data_ready(rd2),
    .abort(abort), .a(q2[0]), .b(q2[1]), .c(q2[2]), .d(q2[3]), .e(q2[4]),
    .f(q2[5]), .g(q2[6]), .h(q2[7]), .sel0(s2[0]), .sel1(s2[1]), .sel2(s2[2]),
    .enable(en2), .busy(bz2), .frame_done(fd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dv    = 1'b0;
    abort = 1'b0;
    din   = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [7:0] pat;
  int         fdc;

  initial begin
    rst_n = 1'b0;
    dv    = 1'b0;
    abort = 1'b0;
    din   = 8'h00;

    // 1: reset values, then LSB-first frame A5
    do_reset();
    check("rst_data", q0, 8'h00);
    check("rst_sel", s0, 3'd0);
    check("rst_en", en0, 1'b1);
    check("rst_rdy", rd0, 1'b1);
    check("rst_busy", bz0, 1'b0);
    check("rst_fd", fd0, 1'b0);
    pat = 8'hA5;
    din = pat; dv = 1'b1;
    tick();
    dv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t1_sel", s0, i);
      check("t1_en", en0, 1'b0);
      check("t1_bit", q0[s0], pat[i]);
      check("t1_fd", fd0, (i == 7));
      tick();
    end
    check("t1_idle_en", en0, 1'b1);
    check("t1_idle_busy", bz0, 1'b0);

    // 2: MSB-first frame 81
    do_reset();
    pat = 8'h81;
    din = pat; dv = 1'b1;
    tick();
    dv = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("t2_sel", s1, 7 - k);
      check("t2_en", en1, 1'b0);
      check("t2_bit", q1[s1], pat[7-k]);
      check("t2_fd", fd1, (k == 7));
      tick();
    end
    check("t2_idle_en", en1, 1'b1);

    // 3: back-to-back FF then 00, no gap
    do_reset();
    din = 8'hFF; dv = 1'b1;
    tick();
    fdc = 0;
    for (int j = 0; j < 16; j++) begin
      check("t3_en", en0, 1'b0);
      check("t3_bit", q0[s0], (j < 8));
      if (fd0) fdc++;
      if (j == 7) check("t3_rdy_last", rd0, 1'b1);
      tick();
      if (j == 0) din = 8'h00;
      if (j == 7) dv = 1'b0;
    end
    check("t3_fd_count", fdc, 2);
    check("t3_idle_en", en0, 1'b1);
    check("t3_idle_busy", bz0, 1'b0);

    // 4: GAP=3 with valid held high
    do_reset();
    pat = 8'h3C;
    din = pat; dv = 1'b1;
    tick();
    for (int j = 0; j < 8; j++) begin
      check("t4_run_en", en2, 1'b0);
      check("t4_bit", q2[s2], pat[j]);
      if (j == 7) check("t4_rdy_last", rd2, 1'b0);
      tick();
    end
    for (int gi = 0; gi < 3; gi++) begin
      check("t4_gap_en", en2, 1'b1);
      check("t4_gap_busy", bz2, 1'b1);
      check("t4_gap_rdy", rd2, 1'b0);
      tick();
    end
    check("t4_idle_busy", bz2, 1'b0);
    check("t4_idle_rdy", rd2, 1'b1);
    check("t4_idle_en", en2, 1'b1);
    tick();
    dv = 1'b0;
    check("t4_next_en", en2, 1'b0);
    check("t4_next_sel", s2, 3'd0);

    // 5: abort at sel=3, new accept the cycle after
    do_reset();
    din = 8'h5A; dv = 1'b1;
    tick();
    dv = 1'b0;
    tick(); tick(); tick();
    check("t5_sel3", s0, 3'd3);
    abort = 1'b1; din = 8'h0F; dv = 1'b1;
    #1;
    check("t5_abort_rdy", rd0, 1'b0);
    tick();
    abort = 1'b0;
    #1;
    check("t5_en", en0, 1'b1);
    check("t5_sel", s0, 3'd0);
    check("t5_fd", fd0, 1'b0);
    check("t5_data_kept", q0, 8'h5A);
    check("t5_rdy", rd0, 1'b1);
    tick();
    dv = 1'b0;
    check("t5_new_en", en0, 1'b0);
    check("t5_new_sel", s0, 3'd0);
    check("t5_new_data", q0, 8'h0F);

    // 6: reset mid-frame at sel=5, then abort in IDLE does not block accept
    do_reset();
    din = 8'h96; dv = 1'b1;
    tick();
    dv = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    check("t6_sel5", s0, 3'd5);
    rst_n = 1'b0;
    tick();
    check("t6_data", q0, 8'h00);
    check("t6_sel", s0, 3'd0);
    check("t6_en", en0, 1'b1);
    check("t6_busy", bz0, 1'b0);
    check("t6_fd", fd0, 1'b0);
    check("t6_rdy", rd0, 1'b1);
    rst_n = 1'b1;
    tick();
    check("t6_idle_en", en0, 1'b1);
    check("t6_idle_busy", bz0, 1'b0);
    abort = 1'b1; din = 8'hC3; dv = 1'b1;
    #1;
    check("t6_abort_idle_rdy", rd0, 1'b1);
    tick();
    dv = 1'b0; abort = 1'b0;
    check("t6_acc_en", en0, 1'b0);
    check("t6_acc_sel", s0, 3'd0);
    check("t6_acc_data", q0, 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
